// File: rtl/simd_issue_ctrl.sv
// Issue/writeback controller for the 4-lane x 32-bit SIMD ALU, with a 128-bit register file.
// Optional macro SIMD_R0_ZERO_EN hardwires register 0 to zero.
module simd_issue_ctrl #(
  parameter int unsigned NREG = 8,
  parameter int unsigned AW   = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [3:0]    instr_op,
  input  logic [AW-1:0] instr_rd,
  input  logic [AW-1:0] instr_rs1,
  input  logic [AW-1:0] instr_rs2,
  output logic [127:0]  alu_operand1,
  output logic [127:0]  alu_operand2,
  output logic [3:0]    alu_op,
  input  logic [127:0]  alu_result,
  input  logic          alu_zero,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [127:0]  ld_data,
  input  logic [AW-1:0] rd_addr,
  output logic [127:0]  rd_data,
  output logic          done,
  output logic          zero_out
);

  typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

  state_e              r_state;
  state_e              w_state_d;
  logic [127:0]        r_regs [NREG];
  logic [127:0]        r_opnd1;
  logic [127:0]        r_opnd2;
  logic [3:0]          r_op;
  logic [AW-1:0]       r_rd;
  logic [127:0]        r_res;
  logic                r_zero;
  logic                r_zero_out;
  logic                r_done;
  logic                w_accept;
  logic [NREG-1:0]     w_wb_we;
  logic [NREG-1:0]     w_ld_we;

  assign w_accept    = instr_valid && (r_state == StIdle);
  assign instr_ready = (r_state == StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (instr_valid) w_state_d = StExec;
      StExec:  w_state_d = StWb;
      StWb:    w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opnd1    <= '0;
      r_opnd2    <= '0;
      r_op       <= '0;
      r_rd       <= '0;
      r_res      <= '0;
      r_zero     <= 1'b0;
      r_zero_out <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= (r_state == StWb);
      // Sources are sampled here, so rs == rd uses the pre-writeback value.
      if (w_accept) begin
        r_opnd1 <= r_regs[instr_rs1];
        r_opnd2 <= r_regs[instr_rs2];
        r_op    <= instr_op;
        r_rd    <= instr_rd;
      end
      if (r_state == StExec) begin
        r_res  <= alu_result;
        r_zero <= alu_zero;
      end
      if (r_state == StWb) begin
        r_zero_out <= r_zero;
      end
    end
  end

  // Writeback has priority over a host load to the same register.
  always_comb begin
    w_wb_we = '0;
    w_ld_we = '0;
    for (int i = 0; i < int'(NREG); i++) begin
      w_wb_we[i] = (r_state == StWb) && (r_rd == AW'(i));
      w_ld_we[i] = ld_en && (ld_addr == AW'(i)) && !w_wb_we[i];
    end
`ifdef SIMD_R0_ZERO_EN
    w_wb_we[0] = 1'b0;
    w_ld_we[0] = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NREG); i++) begin
        if (w_wb_we[i]) begin
          r_regs[i] <= r_res;
        end else if (w_ld_we[i]) begin
          r_regs[i] <= ld_data;
        end
      end
    end
  end

`ifdef SIMD_R0_ZERO_EN
  assign rd_data = (rd_addr == '0) ? '0 : r_regs[rd_addr];
`else
  assign rd_data = r_regs[rd_addr];
`endif

  assign alu_operand1 = r_opnd1;
  assign alu_operand2 = r_opnd2;
  assign alu_op       = r_op;
  assign done         = r_done;
  assign zero_out     = r_zero_out;

endmodule

// File: tb/tb_simd_issue_ctrl.sv
// Self-checking bench for simd_issue_ctrl: XOR ALU stub, cycle-level reference model,
// directed cases with literal expectations, then randomized traffic.
module tb_simd_issue_ctrl;
  localparam int NREG = 8;
  localparam int AW   = 3;
`ifdef SIMD_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  localparam logic [127:0] R1V = 128'h0000000F_00000007_00000003_00000001;
  localparam logic [127:0] XV  = 128'h0000000F_00000007_00000003_00000000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          instr_valid;
  logic          instr_ready;
  logic [3:0]    instr_op;
  logic [AW-1:0] instr_rd, instr_rs1, instr_rs2;
  logic [127:0]  alu_operand1, alu_operand2, alu_result;
  logic [3:0]    alu_op;
  logic          alu_zero;
  logic          ld_en;
  logic [AW-1:0] ld_addr, rd_addr;
  logic [127:0]  ld_data, rd_data;
  logic          done, zero_out;

  simd_issue_ctrl #(.NREG(NREG), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
    .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
    .alu_operand1(alu_operand1), .alu_operand2(alu_operand2), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .done(done), .zero_out(zero_out)
  );

  assign alu_result = alu_operand1 ^ alu_operand2;
  assign alu_zero   = (alu_result == '0);

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: one outstanding instruction whose result is known at acceptance
  // and becomes architecturally visible two edges later.
  logic [127:0]  m_regs [NREG];
  bit            m_pend, m_done, m_zero, m_acc, m_wb;
  int            ncyc = 0;
  int            m_acc_cyc;
  logic [AW-1:0] m_rd;
  logic [127:0]  m_res, m_op1, m_op2, m_a, m_b;
  logic [3:0]    m_op;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) m_regs[i] = '0;
      m_pend = 0; m_done = 0; m_zero = 0; m_acc_cyc = 0;
      m_rd = '0; m_res = '0; m_op1 = '0; m_op2 = '0; m_op = '0;
    end else begin
      ncyc++;
      m_acc = instr_valid && !m_pend;
      m_a = m_regs[instr_rs1];
      m_b = m_regs[instr_rs2];
      m_wb = m_pend && (ncyc == m_acc_cyc + 2);
      m_done = m_wb;
      if (m_wb) begin
        if (!(R0Z && m_rd == 0)) m_regs[m_rd] = m_res;
        m_zero = (m_res == '0);
        m_pend = 0;
      end
      if (ld_en && !(m_wb && ld_addr == m_rd) && !(R0Z && ld_addr == 0))
        m_regs[ld_addr] = ld_data;
      if (m_acc) begin
        m_pend = 1; m_acc_cyc = ncyc; m_op = instr_op; m_rd = instr_rd;
        m_op1 = m_a; m_op2 = m_b; m_res = m_a ^ m_b;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("instr_ready", instr_ready, !m_pend);
      check("done", done, m_done);
      check("zero_out", zero_out, m_zero);
      check("alu_op", alu_op, m_op);
      check("alu_operand1", alu_operand1, m_op1);
      check("alu_operand2", alu_operand2, m_op2);
      check("rd_data", rd_data, m_regs[rd_addr]);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [127:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic [AW-1:0] a, input logic [127:0] exp);
    rd_addr = a;
    #1;
    check(name, rd_data, exp);
  endtask

  // Holds the instruction until accepted; returns the model edge index of acceptance.
  task automatic issue(input logic [3:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                       input logic [AW-1:0] rs2, output int acc_cyc);
    bit rdy, got;
    instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
    got = 0; acc_cyc = -1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk); rdy = instr_ready;
      tick();
      if (rdy) begin got = 1; acc_cyc = ncyc; end
    end
    instr_valid = 1'b0;
    if (!got) begin
      checks++; failures++;
      $display("FAIL issue_accept actual=timeout required=accepted");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1;
    bit rdy;
    rst_n = 1'b1; instr_valid = 0; instr_op = 0; instr_rd = 0; instr_rs1 = 0; instr_rs2 = 0;
    ld_en = 0; ld_addr = 0; ld_data = '0; rd_addr = 0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int a = 0; a < NREG; a++) read_chk("reset_reg", AW'(a), '0);
    check("reset_ready", instr_ready, 1);
    check("reset_done", done, 0);

    load(1, R1V);
    load(2, 128'h1);
    issue(4'b0111, 3, 1, 2, t0);
    check("alu_op_T0", alu_op, 4'd7);
    check("done_T0", done, 0);
    tick();
    check("done_T1", done, 0);
    tick();
    check("done_T2", done, 1);
    check("ready_T2", instr_ready, 1);
    check("zero_out_1", zero_out, 0);
    read_chk("r3", 3, XV);

    issue(4'b0111, 5, 1, 2, t0);
    issue(4'b0111, 4, 1, 1, t1);
    check("b2b_spacing", 128'(t1 - t0), 128'd3);
    tick(); tick();
    check("done_b2b", done, 1);
    check("zero_out_b2b", zero_out, 1);
    read_chk("r4", 4, '0);
    read_chk("r5", 5, XV);

    issue(4'b0000, 6, 1, 2, t0);
    tick();
    ld_en = 1'b1; ld_addr = 6; ld_data = 128'hDEAD;
    tick();
    ld_en = 1'b0;
    read_chk("wb_wins", 6, XV);
    issue(4'b0000, 7, 1, 2, t0);
    tick();
    ld_en = 1'b1; ld_addr = 5; ld_data = 128'hDEAD;
    tick();
    ld_en = 1'b0;
    read_chk("wb_both_rd", 7, XV);
    read_chk("wb_both_ld", 5, 128'hDEAD);

    issue(4'b0111, 6, 1, 2, t0);
    rst_n = 1'b0;
    #2;
    check("abort_ready", instr_ready, 1);
    tick();
    rst_n = 1'b1;
    tick();
    check("abort_done_a", done, 0);
    tick();
    check("abort_done_b", done, 0);
    for (int a = 0; a < NREG; a++) read_chk("abort_reg", AW'(a), '0);

    load(1, R1V);
    load(2, 128'h1);
    load(0, 128'h5);
    read_chk("r0_load", 0, R0Z ? 128'h0 : 128'h5);
    issue(4'b0111, 0, 1, 2, t0);
    tick(); tick();
    check("r0_done", done, 1);
    read_chk("r0_wb", 0, R0Z ? 128'h0 : XV);

    for (int n = 0; n < 600; n++) begin
      @(negedge clk); rdy = instr_ready;
      tick();
      if (!instr_valid || rdy) begin
        instr_valid = 1'($urandom_range(0, 1));
        instr_op = 4'($urandom);
        instr_rd = AW'($urandom); instr_rs1 = AW'($urandom); instr_rs2 = AW'($urandom);
      end
      ld_en = ($urandom_range(0, 2) == 0);
      ld_addr = AW'($urandom);
      ld_data = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 7) == 0) ld_data = m_regs[$urandom_range(0, NREG - 1)];
      rd_addr = AW'($urandom);
    end
    instr_valid = 1'b0; ld_en = 1'b0;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
